// File: rtl/mont_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mont_arbiter
// Brief    : Round-robin arbiter sharing one Montgomery multiplier among
//            N_REQ requesters; the grant is held until the result is taken.
// Revision : 1.0
// ============================================================================
module mont_arbiter #(
    parameter int N_REQ     = 2,
    parameter int MOD_WIDTH = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*MOD_WIDTH-1:0] req_a,
    input  logic [N_REQ*MOD_WIDTH-1:0] req_b,
    input  logic [N_REQ*MOD_WIDTH-1:0] req_mod,
    output logic [N_REQ-1:0]           rsp_valid,
    input  logic [N_REQ-1:0]           rsp_ready,
    output logic [MOD_WIDTH-1:0]       rsp_out,
    output logic                       mont_i_valid,
    input  logic                       mont_i_ready,
    output logic [MOD_WIDTH-1:0]       mont_i_a,
    output logic [MOD_WIDTH-1:0]       mont_i_b,
    output logic [MOD_WIDTH-1:0]       mont_i_mod,
    input  logic                       mont_o_valid,
    output logic                       mont_o_ready,
    input  logic [MOD_WIDTH-1:0]       mont_o_out,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy
);

    localparam int c_PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   r_owner;
    logic [c_PTR_W-1:0]   w_grant;
    logic [c_PTR_W:0]     w_idx;
    logic                 w_found;
    logic                 w_accept;
    logic                 w_rsp_done;
    logic [MOD_WIDTH-1:0] r_a;
    logic [MOD_WIDTH-1:0] r_b;
    logic [MOD_WIDTH-1:0] r_mod;
    logic [MOD_WIDTH-1:0] r_rsp;

    // Rotating priority search starting at r_ptr; the extra index bit
    // absorbs the wrap before it is folded back below N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (c_PTR_W+1)'(k);
            if (w_idx >= (c_PTR_W+1)'(N_REQ)) begin
                w_idx = w_idx - (c_PTR_W+1)'(N_REQ);
            end
            if (!w_found && req_valid[w_idx[c_PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[c_PTR_W-1:0];
            end
        end
    end

    assign w_accept   = (r_state == S_IDLE) && w_found;
    assign w_rsp_done = (r_state == S_RESP) && rsp_ready[r_owner];

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (r_state == S_RESP) begin
            rsp_valid[r_owner] = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)     w_next = S_ISSUE;
            S_ISSUE: if (mont_i_ready) w_next = S_WAIT;
            S_WAIT:  if (mont_o_valid) w_next = S_RESP;
            S_RESP:  if (w_rsp_done)   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_mod   <= '0;
            r_rsp   <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant;
                r_a     <= req_a[int'(w_grant)*MOD_WIDTH +: MOD_WIDTH];
                r_b     <= req_b[int'(w_grant)*MOD_WIDTH +: MOD_WIDTH];
                r_mod   <= req_mod[int'(w_grant)*MOD_WIDTH +: MOD_WIDTH];
            end
            if ((r_state == S_WAIT) && mont_o_valid) begin
                r_rsp <= mont_o_out;
            end
            // Priority rotates only once the owner has taken its result.
            if (w_rsp_done) begin
                if (r_owner == c_PTR_W'(N_REQ-1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= r_owner + 1'b1;
                end
            end
        end
    end

    assign mont_i_valid = (r_state == S_ISSUE);
    assign mont_o_ready = (r_state == S_WAIT);
    assign mont_i_a     = r_a;
    assign mont_i_b     = r_b;
    assign mont_i_mod   = r_mod;
    assign rsp_out      = r_rsp;
    assign owner        = r_owner;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire
